// File: rtl/fc_data_mover_bram_nc_if.sv
// ---------------------------------------------------------------------------
// fc_data_mover_bram_nc_if
//   Bundles the three BRAM ports driven by the FC data mover.
//   b0 : node BRAM, read-only from the mover (addr/ce/we/d out, q in)
//   b1 : weight BRAM, read-only from the mover (addr/ce/we/d out, q in)
//   b2 : result BRAM, write-only from the mover (addr/ce/we/d out)
//   master modport : the data mover
//   slave modport  : the memory side
// ---------------------------------------------------------------------------
interface fc_data_mover_bram_nc_if #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 32,
  parameter int ACC_WIDTH = 32
);
  logic [AWIDTH-1:0]    addr_b0;
  logic                 ce_b0;
  logic                 we_b0;
  logic [DWIDTH-1:0]    d_b0;
  logic [DWIDTH-1:0]    q_b0;

  logic [AWIDTH-1:0]    addr_b1;
  logic                 ce_b1;
  logic                 we_b1;
  logic [DWIDTH-1:0]    d_b1;
  logic [DWIDTH-1:0]    q_b1;

  logic [AWIDTH-1:0]    addr_b2;
  logic                 ce_b2;
  logic                 we_b2;
  logic [ACC_WIDTH-1:0] d_b2;

  modport master (
    output addr_b0, ce_b0, we_b0, d_b0,
    input  q_b0,
    output addr_b1, ce_b1, we_b1, d_b1,
    input  q_b1,
    output addr_b2, ce_b2, we_b2, d_b2
  );

  modport slave (
    input  addr_b0, ce_b0, we_b0, d_b0,
    output q_b0,
    input  addr_b1, ce_b1, we_b1, d_b1,
    output q_b1,
    input  addr_b2, ce_b2, we_b2, d_b2
  );
endinterface

// File: rtl/fc_data_mover_bram_nc.sv
// ---------------------------------------------------------------------------
// fc_data_mover_bram_nc
//   Streams i_num_cnt words from node BRAM (b0) and weight BRAM (b1), runs
//   NUM_CORE signed MAC lanes, then writes each lane accumulator to result
//   BRAM (b2) at addresses 0..NUM_CORE-1. Lane 0 occupies the MSBs of the
//   BRAM words and of o_result.
//   FSM: IDLE -> READ -> DRAIN -> WRITE -> DONE -> IDLE (N=0: IDLE -> WRITE).
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   i_run              start pulse, honoured only in IDLE
//   i_num_cnt          word count, latched at start
//   o_idle/o_read/o_write/o_done  state flags (o_done is a one-cycle pulse)
//   o_result           live lane accumulators, final value held after DRAIN
//   bram               b0/b1 read ports and b2 write port (master modport)
// Configuration
//   FC_RELU_EN         when defined, negative lane results are clamped to 0
//                      on the DRAIN edge; timing is unchanged.
// ---------------------------------------------------------------------------
module fc_data_mover_bram_nc #(
  parameter int CNT_BIT       = 31,
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_CORE      = 4,
  parameter int AWIDTH        = 12,
  parameter int MEM_SIZE      = 4096,
  parameter int ACC_WIDTH     = 32,
  parameter int DWIDTH        = NUM_CORE * IN_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_run,
  input  logic [CNT_BIT-1:0]            i_num_cnt,
  output logic                          o_idle,
  output logic                          o_read,
  output logic                          o_write,
  output logic                          o_done,
  output logic [NUM_CORE*ACC_WIDTH-1:0] o_result,
  fc_data_mover_bram_nc_if.master       bram
);

  localparam int LW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [CNT_BIT-1:0]   r_num_cnt;
  logic [CNT_BIT-1:0]   r_rd_cnt;   // words issued; low bits form the read address
  logic                 r_ce_rd;
  logic                 r_valid;    // q_b0/q_b1 carry data requested last cycle
  logic [LW-1:0]        r_lane;
  logic                 r_wr_en;
  logic                 r_idle;
  logic                 r_read;
  logic                 r_write;
  logic                 r_done;
  logic [ACC_WIDTH-1:0] r_acc      [NUM_CORE];
  logic [ACC_WIDTH-1:0] w_acc_next [NUM_CORE];

  // Per-lane MAC: signed product, sign-extended, accumulated modulo 2^ACC_WIDTH.
  for (genvar k = 0; k < NUM_CORE; k++) begin : g_lane
    logic signed [IN_DATA_WIDTH-1:0]   w_node;
    logic signed [IN_DATA_WIDTH-1:0]   w_wegt;
    logic signed [2*IN_DATA_WIDTH-1:0] w_prod;
    logic        [ACC_WIDTH-1:0]       w_sum;

    assign w_node = bram.q_b0[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH];
    assign w_wegt = bram.q_b1[DWIDTH-1-k*IN_DATA_WIDTH -: IN_DATA_WIDTH];
    assign w_prod = w_node * w_wegt;
    // A size cast of a signed operand sign-extends.
    assign w_sum  = r_acc[k] + ACC_WIDTH'(w_prod);

`ifdef FC_RELU_EN
    // DRAIN carries the last word, so clamping here sees the final sum.
    assign w_acc_next[k] = (r_state == ST_DRAIN && w_sum[ACC_WIDTH-1]) ? '0 : w_sum;
`else
    assign w_acc_next[k] = w_sum;
`endif

    assign o_result[(NUM_CORE-1-k)*ACC_WIDTH +: ACC_WIDTH] = r_acc[k];
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_num_cnt <= '0;
      r_rd_cnt  <= '0;
      r_ce_rd   <= 1'b0;
      r_valid   <= 1'b0;
      r_lane    <= '0;
      r_wr_en   <= 1'b0;
      r_idle    <= 1'b1;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_done    <= 1'b0;
      // NOTE: the accumulators are a handful of flops, not a RAM, so they
      // take the async reset like any other register.
      for (int k = 0; k < NUM_CORE; k++) r_acc[k] <= '0;
    end else begin
      r_valid <= r_ce_rd;
      r_done  <= 1'b0;
      if (r_valid) begin
        for (int k = 0; k < NUM_CORE; k++) r_acc[k] <= w_acc_next[k];
      end

      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            assert (i_num_cnt <= CNT_BIT'(MEM_SIZE));
            r_num_cnt <= i_num_cnt;
            r_rd_cnt  <= '0;
            r_idle    <= 1'b0;
            for (int k = 0; k < NUM_CORE; k++) r_acc[k] <= '0;
            if (i_num_cnt == '0) begin
              r_state <= ST_WRITE;
              r_write <= 1'b1;
              r_wr_en <= 1'b1;
              r_lane  <= '0;
            end else begin
              r_state <= ST_READ;
              r_read  <= 1'b1;
              r_ce_rd <= 1'b1;
            end
          end
        end
        ST_READ: begin
          // Address stops at N-1; the last word is still in flight into DRAIN.
          if (r_rd_cnt == r_num_cnt - CNT_BIT'(1)) begin
            r_state <= ST_DRAIN;
            r_read  <= 1'b0;
            r_ce_rd <= 1'b0;
          end else begin
            r_rd_cnt <= r_rd_cnt + CNT_BIT'(1);
          end
        end
        ST_DRAIN: begin
          r_state <= ST_WRITE;
          r_write <= 1'b1;
          r_wr_en <= 1'b1;
          r_lane  <= '0;
        end
        ST_WRITE: begin
          if (r_lane == LW'(NUM_CORE - 1)) begin
            r_state <= ST_DONE;
            r_write <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b1;
            r_lane  <= '0;
          end else begin
            r_lane <= r_lane + LW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_idle  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idle  <= 1'b1;
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_ce_rd <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_idle  = r_idle;
  assign o_read  = r_read;
  assign o_write = r_write;
  assign o_done  = r_done;

  assign bram.addr_b0 = r_rd_cnt[AWIDTH-1:0];
  assign bram.ce_b0   = r_ce_rd;
  assign bram.we_b0   = 1'b0;
  assign bram.d_b0    = '0;
  assign bram.addr_b1 = r_rd_cnt[AWIDTH-1:0];
  assign bram.ce_b1   = r_ce_rd;
  assign bram.we_b1   = 1'b0;
  assign bram.d_b1    = '0;

  // Write data is taken straight from the accumulators so the value settled
  // on the DRAIN edge appears in the first WRITE cycle.
  assign bram.addr_b2 = AWIDTH'(r_lane);
  assign bram.ce_b2   = r_wr_en;
  assign bram.we_b2   = r_wr_en;
  assign bram.d_b2    = r_wr_en ? r_acc[r_lane] : '0;

endmodule

// File: tb/tb_fc_data_mover_bram_nc.sv
// ---------------------------------------------------------------------------
// tb_fc_data_mover_bram_nc
//   Directed bench for fc_data_mover_bram_nc (NUM_CORE=4, 8-bit operands,
//   32-bit accumulators). Node/weight BRAMs are modelled with one-cycle read
//   latency; result writes are captured from the b2 port each cycle.
//   Cycle 0 is the cycle in which i_run is high in IDLE.
// ---------------------------------------------------------------------------
module tb_fc_data_mover_bram_nc;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_run = 1'b0;
  logic [30:0]  i_num_cnt = '0;
  logic         o_idle;
  logic         o_read;
  logic         o_write;
  logic         o_done;
  logic [127:0] o_result;

  fc_data_mover_bram_nc_if #(.AWIDTH(12), .DWIDTH(32), .ACC_WIDTH(32)) bram ();

  fc_data_mover_bram_nc #(
    .CNT_BIT(31), .IN_DATA_WIDTH(8), .NUM_CORE(4),
    .AWIDTH(12), .MEM_SIZE(4096), .ACC_WIDTH(32)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .o_idle    (o_idle),
    .o_read    (o_read),
    .o_write   (o_write),
    .o_done    (o_done),
    .o_result  (o_result),
    .bram      (bram)
  );

  always #5 clk = ~clk;

  logic [31:0] node_mem [4096];
  logic [31:0] wegt_mem [4096];
  logic [31:0] b2_mem   [4];

  // One-cycle-latency read ports.
  always @(posedge clk) begin
    if (bram.ce_b0) bram.q_b0 <= node_mem[bram.addr_b0];
    if (bram.ce_b1) bram.q_b1 <= wegt_mem[bram.addr_b1];
  end

  int n_vec  = 0;
  int n_miss = 0;
  int done_cyc, ce_cnt, max_addr, wr_cnt;
  logic [127:0] exp_res;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input logic [31:0] nv, input logic [31:0] wv);
    for (int i = 0; i < 4096; i++) begin
      node_mem[i] = nv;
      wegt_mem[i] = wv;
    end
  endtask

  // Starts a run from IDLE (called #1 after a posedge), optionally pulses
  // i_run again at cycle 'stray', and returns one cycle after DONE.
  task automatic run(input int n, input int stray);
    done_cyc = -1;
    ce_cnt   = 0;
    max_addr = 0;
    wr_cnt   = 0;
    for (int k = 0; k < 4; k++) b2_mem[k] = 32'hDEADBEEF;
    i_num_cnt = 31'(n);
    i_run     = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= n + 20; c++) begin
      i_run = (c == stray);
      if (bram.ce_b0) begin
        ce_cnt++;
        if (int'(bram.addr_b0) > max_addr) max_addr = int'(bram.addr_b0);
      end
      if (bram.ce_b2 && bram.we_b2) begin
        wr_cnt++;
        if (bram.addr_b2 < 12'd4) b2_mem[bram.addr_b2[1:0]] = bram.d_b2;
      end
      if (o_done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    i_run = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_b2(input string tag, input logic [127:0] expv);
    logic [127:0] e;
    e = expv;
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_b2[%0d]", tag, k), {96'd0, b2_mem[k]}, {96'd0, e[(3-k)*32 +: 32]});
  endtask

  initial begin
    fill(32'h0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle",   {127'd0, o_idle}, 128'd1);
    check("rst_flags",  {125'd0, o_read, o_write, o_done}, 128'd0);
    check("rst_result", o_result, 128'd0);
    check("rst_ce_we",  {124'd0, bram.ce_b0, bram.ce_b1, bram.ce_b2, bram.we_b2}, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Case 1: all ones, full memory
    fill(32'h01010101, 32'h01010101);
    exp_res = {4{32'd4096}};
    run(4096, -1);
    check("c1_done",   done_cyc, 4102);
    check("c1_ce_cnt", ce_cnt, 4096);
    check("c1_maxadr", max_addr, 4095);
    check("c1_wr_cnt", wr_cnt, 4);
    check("c1_result", o_result, exp_res);
    check_b2("c1", exp_res);
    check("c1_idle",   {127'd0, o_idle}, 128'd1);
    check("c1_rd_port_we_d", {62'd0, bram.we_b0, bram.we_b1, bram.d_b0, bram.d_b1}, 128'd0);

    // Case 2: -1 * 2 over 10 words
    fill(32'hFFFFFFFF, 32'h02020202);
`ifdef FC_RELU_EN
    exp_res = 128'd0;
`else
    exp_res = {4{32'hFFFFFFEC}};
`endif
    run(10, -1);
    check("c2_done",   done_cyc, 16);
    check("c2_maxadr", max_addr, 9);
    check("c2_result", o_result, exp_res);
    check_b2("c2", exp_res);

    // Case 3: N = 0
    run(0, -1);
    check("c3_done",   done_cyc, 5);
    check("c3_ce_cnt", ce_cnt, 0);
    check("c3_wr_cnt", wr_cnt, 4);
    check("c3_result", o_result, 128'd0);
    check_b2("c3", 128'd0);

    // Case 4: stray i_run during READ, then a second clean run
    fill(32'h01FF0203, 32'h05050505);
`ifdef FC_RELU_EN
    exp_res = {32'd50, 32'd0, 32'd100, 32'd150};
`else
    exp_res = {32'd50, 32'hFFFFFFCE, 32'd100, 32'd150};
`endif
    run(10, 3);
    check("c4a_done",   done_cyc, 16);
    check("c4a_result", o_result, exp_res);
    run(10, -1);
    check("c4b_done",   done_cyc, 16);
    check("c4b_result", o_result, exp_res);
    check_b2("c4b", exp_res);

    // Case 5: reset at cycle 20 of a full run, then rerun
    fill(32'h01010101, 32'h01010101);
    i_num_cnt = 31'd4096;
    i_run     = 1'b1;
    @(posedge clk); #1;
    i_run = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("c5_in_read", {127'd0, o_read}, 128'd1);
    reset_n = 1'b0;
    #1;
    check("c5_rst_idle",   {127'd0, o_idle}, 128'd1);
    check("c5_rst_ce_we",  {123'd0, o_read, bram.ce_b0, bram.ce_b1, bram.ce_b2, bram.we_b2}, 128'd0);
    check("c5_rst_result", o_result, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_res = {4{32'd4096}};
    run(4096, -1);
    check("c5_done",   done_cyc, 4102);
    check("c5_result", o_result, exp_res);

    // Case 6: per-lane signed extremes, single word
    fill(32'h7F80017F, 32'h7F7FFF01);
`ifdef FC_RELU_EN
    exp_res = {32'd16129, 32'd0, 32'd0, 32'd127};
`else
    exp_res = {32'd16129, 32'hFFFFC080, 32'hFFFFFFFF, 32'd127};
`endif
    run(1, -1);
    check("c6_done",   done_cyc, 7);
    check("c6_ce_cnt", ce_cnt, 1);
    check("c6_maxadr", max_addr, 0);
    check("c6_result", o_result, exp_res);
    check_b2("c6", exp_res);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
